// File: rtl/present_pkg.sv
// Shared PRESENT key-schedule definitions: S-box tables, rotation amount and FSM states.
// The PRE state exists only when PRESENT_KS_INV_EN is defined.
package present_pkg;

    localparam int ROT = 61;

    // Nibble i of each table holds the substitution for input value i.
    localparam logic [63:0] SBOX_TAB     = 64'h21748FE3DA09B65C;
    localparam logic [63:0] INV_SBOX_TAB = 64'hA970364BD21C8FE5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1
`ifdef PRESENT_KS_INV_EN
        , PRE = 2'd2
`endif
    } ks_state_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_TAB[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        return INV_SBOX_TAB[{x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/present_ks_round.sv
// One combinational PRESENT key-schedule step (forward, plus inverse when PRESENT_KS_INV_EN).
// The 128-bit schedule substitutes the two top nibbles and XORs the counter into a different field.
module present_ks_round
    import present_pkg::*;
#(
    parameter int KEY_W = 80
) (
    input  logic [KEY_W-1:0] key_in,
    input  logic [4:0]       rc,
    output logic [KEY_W-1:0] fwd_out
`ifdef PRESENT_KS_INV_EN
    ,
    output logic [KEY_W-1:0] inv_out
`endif
);

    localparam int RC_LO = (KEY_W == 128) ? 62 : 15;

    logic [KEY_W-1:0] rot_l;

    always_comb begin
        rot_l   = {key_in[KEY_W-1-ROT:0], key_in[KEY_W-1:KEY_W-ROT]};
        fwd_out = rot_l;
        fwd_out[KEY_W-1 -: 4] = sbox(rot_l[KEY_W-1 -: 4]);
        if (KEY_W == 128) begin
            fwd_out[KEY_W-5 -: 4] = sbox(rot_l[KEY_W-5 -: 4]);
        end
        fwd_out[RC_LO +: 5] = fwd_out[RC_LO +: 5] ^ rc;
    end

`ifdef PRESENT_KS_INV_EN
    logic [KEY_W-1:0] unmix;

    // Undo the forward step in reverse order: counter XOR, S-box, then rotation.
    always_comb begin
        unmix = key_in;
        unmix[RC_LO +: 5] = unmix[RC_LO +: 5] ^ rc;
        unmix[KEY_W-1 -: 4] = inv_sbox(key_in[KEY_W-1 -: 4]);
        if (KEY_W == 128) begin
            unmix[KEY_W-5 -: 4] = inv_sbox(key_in[KEY_W-5 -: 4]);
        end
        inv_out = {unmix[ROT-1:0], unmix[KEY_W-1:ROT]};
    end
`endif

endmodule

// File: rtl/present_keysched.sv
// PRESENT round-key generator streaming ROUNDS+1 keys over a valid/ready handshake.
// Define PRESENT_KS_INV_EN to add the dec port and reverse-order (decryption) schedules.
module present_keysched
    import present_pkg::*;
#(
    parameter int KEY_W  = 80,
    parameter int ROUNDS = 31
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
`ifdef PRESENT_KS_INV_EN
    input  logic             dec,
`endif
    output logic [63:0]      rk,
    output logic [5:0]       rk_idx,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             busy,
    output logic             done
);

    if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
        $error("present_keysched: KEY_W must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("present_keysched: ROUNDS must be in 1..31");
    end

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS + 1);

    ks_state_e        state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [5:0]       idx_q, idx_d;
    logic             done_q, done_d;
    logic [4:0]       rc;
    logic [KEY_W-1:0] fwd_key;

`ifdef PRESENT_KS_INV_EN
    logic             dec_q, dec_d;
    logic [KEY_W-1:0] inv_key;
`endif

    present_ks_round #(.KEY_W(KEY_W)) u_round (
        .key_in  (key_q),
        .rc      (rc),
        .fwd_out (fwd_key)
`ifdef PRESENT_KS_INV_EN
        ,
        .inv_out (inv_key)
`endif
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        rc      = idx_q[4:0];
`ifdef PRESENT_KS_INV_EN
        dec_d   = dec_q;
        // Going backwards from key i needs the counter used to produce it, i.e. i-1.
        if (dec_q && state_q == EMIT) begin
            rc = idx_q[4:0] - 5'd1;
        end
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key;
                    idx_d   = 6'd1;
                    state_d = EMIT;
`ifdef PRESENT_KS_INV_EN
                    dec_d   = dec;
                    if (dec) begin
                        state_d = PRE;
                    end
`endif
                end
            end
`ifdef PRESENT_KS_INV_EN
            PRE: begin
                key_d = fwd_key;
                idx_d = idx_q + 6'd1;
                if (idx_q == 6'(ROUNDS)) begin
                    state_d = EMIT;
                end
            end
`endif
            EMIT: begin
                if (rk_ready) begin
`ifdef PRESENT_KS_INV_EN
                    if (dec_q) begin
                        if (idx_q == 6'd1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            key_d = inv_key;
                            idx_d = idx_q - 6'd1;
                        end
                    end else
`endif
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d = fwd_key;
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RN) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
`ifdef PRESENT_KS_INV_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
`ifdef PRESENT_KS_INV_EN
            dec_q   <= dec_d;
`endif
        end
    end

    assign rk       = key_q[KEY_W-1 -: 64];
    assign rk_idx   = idx_q;
    assign rk_valid = (state_q == EMIT);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_present_keysched.sv
// Bench for present_keysched: random keys and ready patterns checked every cycle against a
// schedule-table model, plus directed stall/start/reset cases and a KEY_W=128 instance.
module tb_present_keysched;

    logic         CK = 1'b0;
    logic         RN = 1'b1;
    logic         start = 1'b0;
    logic         rk_ready = 1'b0;
    logic [79:0]  key = '0;
`ifdef PRESENT_KS_INV_EN
    logic         dec = 1'b0;
`endif
    logic [63:0]  rk;
    logic [5:0]   rk_idx;
    logic         rk_valid, busy, done;

    logic         start2 = 1'b0;
    logic         ready2 = 1'b1;
    logic [127:0] key2 = '0;
    logic [63:0]  rk2;
    logic [5:0]   rk_idx2;
    logic         rk_valid2, busy2, done2;

    int checks = 0;
    int errors = 0;

    always #5 CK = ~CK;

    present_keysched #(.KEY_W(80), .ROUNDS(31)) dut (
        .CK(CK), .RN(RN), .start(start), .key(key),
`ifdef PRESENT_KS_INV_EN
        .dec(dec),
`endif
        .rk(rk), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .busy(busy), .done(done)
    );

    present_keysched #(.KEY_W(128), .ROUNDS(31)) dut128 (
        .CK(CK), .RN(RN), .start(start2), .key(key2),
`ifdef PRESENT_KS_INV_EN
        .dec(1'b0),
`endif
        .rk(rk2), .rk_idx(rk_idx2), .rk_valid(rk_valid2), .rk_ready(ready2),
        .busy(busy2), .done(done2)
    );

    // Reference: the full list of round keys is built up front; the schedule is a walk over it.
    int unsigned sbox_m [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    logic [63:0] sched [1:32];
    int          m_mode = 0;   // 0 idle, 1 precompute, 2 emitting
    int          m_idx = 0;
    int          m_pre = 0;
    bit          m_dec = 0;
    bit          m_done = 0;
    logic [63:0] m_rk = '0;
    bit          cmp_en = 0;

    task automatic build_sched(input logic [79:0] k_in);
        logic [79:0] k = k_in;
        for (int i = 1; i <= 32; i++) begin
            sched[i] = 64'(k >> 16);
            k = (k << 61) | (k >> 19);
            k[79:76] = 4'(sbox_m[k[79:76]]);
            k = k ^ (80'(i) << 15);
        end
    endtask

    always @(posedge CK) begin
        if (RN) begin
            m_mode = 0; m_idx = 0; m_done = 0; m_rk = '0;
        end else begin
            m_done = 0;
            case (m_mode)
                0: if (start) begin
                    build_sched(key);
                    m_idx = 1;
                    m_rk  = sched[1];
`ifdef PRESENT_KS_INV_EN
                    m_dec = dec;
`else
                    m_dec = 0;
`endif
                    if (m_dec) begin m_mode = 1; m_pre = 31; end
                    else m_mode = 2;
                end
                1: begin
                    m_pre--;
                    if (m_pre == 0) begin m_mode = 2; m_idx = 32; m_rk = sched[32]; end
                end
                default: if (rk_ready) begin
                    if ((m_dec && m_idx == 1) || (!m_dec && m_idx == 32)) begin
                        m_mode = 0; m_done = 1;
                    end else begin
                        m_idx = m_dec ? m_idx - 1 : m_idx + 1;
                        m_rk  = sched[m_idx];
                    end
                end
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge CK) begin
        if (cmp_en) begin
            checkOutput("rk_valid", 64'(rk_valid), 64'(m_mode == 2));
            checkOutput("busy", 64'(busy), 64'(m_mode != 0));
            checkOutput("done", 64'(done), 64'(m_done));
            if (m_mode != 1) begin
                checkOutput("rk_idx", 64'(rk_idx), 64'(m_idx));
                checkOutput("rk", rk, m_rk);
            end
        end
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic applyStimulus(input logic [79:0] k, input bit d);
        key   = k;
        start = 1'b1;
`ifdef PRESENT_KS_INV_EN
        dec   = d;
`else
        if (d) $display("[TB] reverse request ignored in forward-only build");
`endif
        tick();
        start = 1'b0;
    endtask

    task automatic waitIdx(input int target, input int budget);
        int n = 0;
        while (!(rk_valid && rk_idx == 6'(target)) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("wait_idx", 64'(rk_idx), 64'(target));
    endtask

    task automatic runToDone(input int budget, input bit rand_ready, output int accepted);
        int n = 0;
        accepted = 0;
        while (n < budget) begin
            if (rand_ready) rk_ready = 1'($urandom_range(0, 1));
            if (done) break;
            if (rk_valid && rk_ready) accepted++;
            tick();
            n++;
        end
        checkOutput("done_within_budget", 64'(done), 64'd1);
    endtask

    function automatic logic [79:0] rand_key();
        return {16'($urandom()), $urandom(), $urandom()};
    endfunction

    initial begin
        int acc;
        int n;
        logic [79:0] k;

        tick();
        cmp_en = 1;
        tick();
        checkOutput("reset_idx", 64'(rk_idx), 64'd0);
        checkOutput("reset_valid", 64'(rk_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_rk", rk, 64'd0);
        RN = 1'b0;
        tick();

        // Zero key, always ready: fixed first two keys and a full 32-key run.
        rk_ready = 1'b1;
        applyStimulus(80'd0, 1'b0);
        checkOutput("model_k1", sched[1], 64'h0);
        checkOutput("model_k2", sched[2], 64'hC000000000000000);
        checkOutput("zero_k1", rk, 64'h0);
        checkOutput("zero_idx1", 64'(rk_idx), 64'd1);
        tick();
        checkOutput("zero_k2", rk, 64'hC000000000000000);
        checkOutput("zero_idx2", 64'(rk_idx), 64'd2);
        runToDone(80, 1'b0, acc);
        checkOutput("zero_accepted", 64'(acc), 64'd31);
        tick();
        checkOutput("zero_busy_after", 64'(busy), 64'd0);

        // Random keys with random back-pressure.
        for (int r = 0; r < 3; r++) begin
            applyStimulus(rand_key(), 1'b0);
            runToDone(400, 1'b1, acc);
            tick();
        end

        // Stall at 7, ignored start at 10, reset at 15.
        rk_ready = 1'b1;
        applyStimulus(rand_key(), 1'b0);
        waitIdx(7, 20);
        rk_ready = 1'b0;
        repeat (5) tick();
        checkOutput("stall_hold_idx", 64'(rk_idx), 64'd7);
        rk_ready = 1'b1;
        tick();
        checkOutput("stall_release_idx", 64'(rk_idx), 64'd8);
        waitIdx(10, 10);
        k = rand_key();
        key = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start_ignored_idx", 64'(rk_idx), 64'd11);
        waitIdx(15, 10);
        RN = 1'b1;
        tick();
        RN = 1'b0;
        checkOutput("abort_valid", 64'(rk_valid), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_idx", 64'(rk_idx), 64'd0);
        applyStimulus(rand_key(), 1'b0);
        checkOutput("restart_idx", 64'(rk_idx), 64'd1);

        // Start coinciding with the final handshake must not relaunch.
        waitIdx(32, 40);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("last_done", 64'(done), 64'd1);
        checkOutput("last_busy", 64'(busy), 64'd0);
        tick();
        checkOutput("last_start_ignored", 64'(busy), 64'd0);

`ifdef PRESENT_KS_INV_EN
        // Reverse order: keys arrive 32..1 after the precompute phase.
        applyStimulus(rand_key(), 1'b1);
        dec = 1'b0;
        n = 1;
        while (!rk_valid && n < 60) begin tick(); n++; end
        checkOutput("rev_latency", 64'(n), 64'd32);
        checkOutput("rev_first_idx", 64'(rk_idx), 64'd32);
        runToDone(400, 1'b1, acc);
        tick();
`endif

        // 128-bit key width.
        key2 = '0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        checkOutput("k128_valid", 64'(rk_valid2), 64'd1);
        checkOutput("k128_k1", rk2, 64'h0);
        checkOutput("k128_idx1", 64'(rk_idx2), 64'd1);
        tick();
        checkOutput("k128_k2", rk2, 64'hCC00000000000000);
        checkOutput("k128_idx2", 64'(rk_idx2), 64'd2);
        n = 0;
        while (!done2 && n < 60) begin tick(); n++; end
        checkOutput("k128_done", 64'(done2), 64'd1);
        tick();
        checkOutput("k128_busy_after", 64'(busy2), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/present_keysched.md
PRESENT_KEYSCHED -- requirements
Module: present_keysched

Interface
REQ-001 SHALL have parameter KEY_W, default 80: key width, legal values 80 or 128, any other value is a elaboration error.
REQ-002 SHALL have parameter ROUNDS, default 31: number of schedule updates, giving ROUNDS+1 round keys.
REQ-003 SHALL have port CK, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port RN, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1: single-cycle request to load key and begin a schedule.
REQ-006 SHALL have port key, input, KEY_W: master key, sampled only on an accepted start.
REQ-007 SHALL have port dec, input, 1, present only with PRESENT_KS_INV_EN: sampled with start; 1 selects reverse key order.
REQ-008 SHALL have port rk, output, 64: current round key.
REQ-009 SHALL have port rk_idx, output, 6: index of rk, 1..ROUNDS+1.
REQ-010 SHALL have port rk_valid, output, 1: rk/rk_idx are valid.
REQ-011 SHALL have port rk_ready, input, 1: consumer accepts rk when high with rk_valid.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse after the last round key is accepted.

Function
REQ-014 SHALL implement states IDLE, PRE (inverse build only), EMIT.
REQ-015 IDLE: start loads key into the key register, sets rk_idx=1, goes to EMIT (or PRE if dec=1); start outside IDLE SHALL be ignored.
REQ-016 rk SHALL equal key register bits [KEY_W-1:KEY_W-64]; rk_valid SHALL be high in EMIT only, first asserting the cycle after start (forward).
REQ-017 Forward update, rc = rk_idx[4:0]: rotate left 61; sbox on [79:76] (KEY_W=80) or on [127:124] and [123:120] (KEY_W=128); XOR rc into [19:15] (80) or [66:62] (128).
REQ-018 On rk_valid & rk_ready with rk_idx < ROUNDS+1: forward update applied, rk_idx increments; rk/rk_idx SHALL hold stable while rk_valid & !rk_ready.
REQ-019 On rk_valid & rk_ready with rk_idx = ROUNDS+1 (forward) or 1 (reverse): return to IDLE, done=1 for exactly that next cycle, key register unchanged.
REQ-020 start in the same cycle as the final handshake SHALL be ignored (FSM not yet IDLE).
REQ-021 rc arithmetic SHALL be 5-bit; ROUNDS>31 is unsupported and an elaboration error.

Reset
REQ-022 RN=1 at a clock edge SHALL force IDLE, rk_idx=0, rk_valid=0, busy=0, done=0, key register=0, aborting any schedule mid-operation.

Configuration
REQ-023 With PRESENT_KS_INV_EN defined: PRE applies ROUNDS forward updates in ROUNDS cycles, no rk_valid, then EMIT with rk_idx=ROUNDS+1, each handshake applying the inverse update (XOR rc=rk_idx-1, inverse sbox, rotate right 61) and decrementing rk_idx; first rk_valid ROUNDS+1 cycles after start.
REQ-024 Without PRESENT_KS_INV_EN: no dec port, no PRE state, no inverse sbox logic; forward only.

Structure
REQ-025 Shared package present_pkg SHALL hold the 16-entry sbox and inverse sbox tables, ROT=61, and the state enumeration.
REQ-026 Sub-module present_ks_round SHALL implement one combinational forward/inverse update parameterised by KEY_W; FSM, counter and register stay in the top.

Verification
REQ-027 KEY_W=80, key=0, start, rk_ready=1 -> cycle+1 rk=0x0000000000000000 idx=1; next rk=0xC000000000000000 idx=2; 32 keys, done pulse, busy low.
REQ-028 KEY_W=128, key=0 -> rk idx=1 0x0, idx=2 0xCC00000000000000.
REQ-029 rk_ready held low 5 cycles at idx=7 -> rk, rk_idx stable, no advance; release -> idx=8 next cycle.
REQ-030 start pulsed at idx=10 -> ignored, sequence continues to idx=11 unchanged.
REQ-031 RN=1 at idx=15 -> next cycle rk_valid=0, busy=0, rk_idx=0; new start restarts from idx=1.
REQ-032 PRESENT_KS_INV_EN, KEY_W=80, random key, dec=1 -> first rk_valid 32 cycles after start, keys idx 32..1 equal forward run reversed, done after idx=1.
